lkt_pipe: RTL
=============

LKT_PIPE -- requirements
Module: lkt_pipe

Interface
REQ-001 SHALL have parameter RESULT_WIDTH, default 3: bits per table entry and per lookup result.
REQ-002 SHALL have parameter NUM_LOOKUPS, default 8: independent lookups per transaction.
REQ-003 SHALL have parameter NUM_CHOICES, default 2: entries per lookup, one-hot selected; legal range 2..16.
REQ-004 SHALL have parameter PIPE_STAGES, default 2: register stages from accept to output; legal range 1..4.
REQ-005 SHALL have parameter DEFAULT_RESULT, default 0: result when a select group has no bit set.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-007 clk  input  1  sole clock; all state on posedge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 cfg_we  input  1  table write strobe.
REQ-010 cfg_lookup  input  clog2(NUM_LOOKUPS)  lookup index of write.
REQ-011 cfg_choice  input  clog2(NUM_CHOICES)  choice index of write.
REQ-012 cfg_data  input  RESULT_WIDTH  entry value written.
REQ-013 in_valid  input  1  transaction offered.
REQ-014 in_ready  output  1  transaction accepted when in_valid && in_ready.
REQ-015 input_i  input  NUM_LOOKUPS*NUM_CHOICES  one-hot select groups; group k = bits [k*NUM_CHOICES +: NUM_CHOICES].
REQ-016 out_valid  output  1  result available.
REQ-017 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-018 output_o  output  RESULT_WIDTH*NUM_LOOKUPS  result k at [k*RESULT_WIDTH +: RESULT_WIDTH].
REQ-019 err_o  output  NUM_LOOKUPS  per-lookup select error, aligned with output_o.
REQ-020 cnt_clr  input  1  synchronous clear of err_cnt_o.
REQ-021 err_cnt_o  output  16  saturating count of delivered transactions with any error.

Function
REQ-022 Table: NUM_LOOKUPS x NUM_CHOICES entries held in registers; cfg_we writes entry [cfg_lookup][cfg_choice]; visible from next cycle.
REQ-023 Out-of-range cfg_lookup/cfg_choice on cfg_we SHALL be ignored (no entry modified).
REQ-024 Lookup SHALL be evaluated with the table contents of the accept cycle; a write in the same cycle does not affect that transaction (read-before-write).
REQ-025 Group exactly one-hot: result = selected entry, err bit 0.
REQ-026 Group all zero: result = DEFAULT_RESULT, err bit 1.
REQ-027 Group with >1 bit set: result = entry of lowest set index, err bit 1.
REQ-028 Pipeline: PIPE_STAGES valid-tagged stages; a stage advances when next stage empty or downstream ready; throughput one transaction per cycle with out_ready held high.
REQ-029 Latency: first out_valid exactly PIPE_STAGES cycles after accept edge when unstalled.
REQ-030 in_ready = !stage0_valid || stage0 advances; combinational from out_ready allowed, not from in_valid.
REQ-031 While out_valid && !out_ready, output_o and err_o SHALL hold stable; no transaction dropped or duplicated; order preserved.
REQ-032 err_cnt_o increments by 1 on each out_valid && out_ready with |err_o; saturates at 16'hFFFF.
REQ-033 cnt_clr sets err_cnt_o to 0 next cycle; takes priority over a same-cycle increment.

Reset
REQ-034 rst asserted SHALL immediately clear all stage valids, table entries to 0, err_cnt_o to 0.
REQ-035 During reset: out_valid=0, output_o=0, err_o=0, in_ready=0; in_ready=1 from first clk edge after rst deasserts.
REQ-036 Reset mid-operation SHALL discard all in-flight transactions; no out_valid for them afterwards.

Verification
REQ-037 Write entry[3][1]=3'h5, entry[3][0]=3'h2; send input_i group3=2'b10, others 2'b01 with table 0 -> output_o[11:9]=5, others 0, err_o=0, out_valid 2 cycles after accept.
REQ-038 Group0=2'b00, group1=2'b11 with entry[1][0]=4, entry[1][1]=6 -> result0=DEFAULT_RESULT, result1=4, err_o=8'h03, err_cnt_o 0->1 on handoff.
REQ-039 Stream 10 back-to-back transactions, out_ready low cycles 4-7 -> outputs held stable during stall, all 10 delivered in order, in_ready low once both stages full.
REQ-040 cfg_we entry[0][0]=7 in same cycle as accepted transaction selecting it -> that result 0; next transaction -> 7.
REQ-041 Preload err_cnt_o to 16'hFFFE via errored transactions, deliver 3 more -> stays 16'hFFFF; cnt_clr with errored handoff same cycle -> 0.
REQ-042 Assert rst with 2 transactions in flight -> out_valid drops immediately, table reads 0, no stale output after release.

Source files
------------

// File: rtl/lkt_pipe_if.sv
// Stream bundle for lkt_pipe: select groups in, lookup results out.
// Ports: in_valid/in_ready/input_i upstream; out_valid/out_ready/output_o/err_o downstream.
interface lkt_pipe_if #(
   parameter int RESULT_WIDTH = 3,
   parameter int NUM_LOOKUPS  = 8,
   parameter int NUM_CHOICES  = 2
);
   logic                                in_valid;
   logic                                in_ready;
   logic [NUM_LOOKUPS*NUM_CHOICES-1:0]  input_i;
   logic                                out_valid;
   logic                                out_ready;
   logic [RESULT_WIDTH*NUM_LOOKUPS-1:0] output_o;
   logic [NUM_LOOKUPS-1:0]              err_o;

   modport master (
      output in_valid, input_i, out_ready,
      input  in_ready, out_valid, output_o, err_o
   );

   modport slave (
      input  in_valid, input_i, out_ready,
      output in_ready, out_valid, output_o, err_o
   );
endinterface

// File: rtl/lkt_pipe.sv
// Pipelined one-hot table lookup: NUM_LOOKUPS groups, each picks one of NUM_CHOICES entries.
// Ports: clk, rst (async high), cfg_* table write, bus (stream slave), cnt_clr, err_cnt_o.
module lkt_pipe #(
   parameter int RESULT_WIDTH = 3,
   parameter int NUM_LOOKUPS  = 8,
   parameter int NUM_CHOICES  = 2,
   parameter int PIPE_STAGES  = 2,
   parameter logic [RESULT_WIDTH-1:0] DEFAULT_RESULT = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cfg_we,
   input  logic [$clog2(NUM_LOOKUPS)-1:0]  cfg_lookup,
   input  logic [$clog2(NUM_CHOICES)-1:0]  cfg_choice,
   input  logic [RESULT_WIDTH-1:0]         cfg_data,
   lkt_pipe_if.slave                       bus,
   input  logic                            cnt_clr,
   output logic [15:0]                     err_cnt_o
);
   localparam int RW = RESULT_WIDTH;
   localparam int NL = NUM_LOOKUPS;
   localparam int NC = NUM_CHOICES;
   localparam int PS = PIPE_STAGES;

   logic [RW-1:0]    tbl_q [NL][NC];
   logic [RW-1:0]    tbl_d [NL][NC];
   logic             cfg_hit;

   logic [RW*NL-1:0] lk_res;
   logic [NL-1:0]    lk_err;
   logic [RW-1:0]    pick;
   logic             hit;

   logic [PS-1:0]    v_q;
   logic [PS-1:0]    v_d;
   logic [PS-1:0]    free;
   logic [RW*NL-1:0] res_q [PS];
   logic [RW*NL-1:0] res_d [PS];
   logic [NL-1:0]    err_q [PS];
   logic [NL-1:0]    err_d [PS];
   logic             rdy_q;
   logic             rdy_d;
   logic             take;

   logic [15:0]      cnt_q;
   logic [15:0]      cnt_d;

   // Table write; out-of-range indices leave every entry untouched.
   always_comb begin
      cfg_hit = cfg_we && (32'(cfg_lookup) < NL) && (32'(cfg_choice) < NC);
      tbl_d = tbl_q;
      if (cfg_hit) begin
         tbl_d[cfg_lookup][cfg_choice] = cfg_data;
      end
   end

   // Lookup reads the registered table, so a same-cycle write is not seen.
   always_comb begin
      lk_res = '0;
      lk_err = '0;
      pick   = DEFAULT_RESULT;
      hit    = 1'b0;
      for (int k = 0; k < NL; k++) begin
         pick = DEFAULT_RESULT;
         hit  = 1'b0;
         for (int c = 0; c < NC; c++) begin
            if (!hit && bus.input_i[k*NC+c]) begin
               pick = tbl_q[k][c];
               hit  = 1'b1;
            end
         end
         lk_res[k*RW +: RW] = pick;
         lk_err[k] = !$onehot(bus.input_i[k*NC +: NC]);
      end
   end

   // Stage i can load when any stage at or after it is empty,
   // or the output is being consumed.
   always_comb begin
      free = '0;
      for (int i = 0; i < PS; i++) begin
         free[i] = bus.out_ready;
         for (int j = i; j < PS; j++) begin
            if (!v_q[j]) begin
               free[i] = 1'b1;
            end
         end
      end
   end

   // rdy_q keeps in_ready low until the first edge after reset.
   assign bus.in_ready = rdy_q && free[0];
   assign take = bus.in_valid && bus.in_ready;

   always_comb begin
      v_d   = v_q;
      res_d = res_q;
      err_d = err_q;
      rdy_d = 1'b1;
      if (free[0]) begin
         v_d[0] = take;
         if (take) begin
            res_d[0] = lk_res;
            err_d[0] = lk_err;
         end
      end
      for (int i = 1; i < PS; i++) begin
         if (free[i]) begin
            v_d[i]   = v_q[i-1];
            res_d[i] = res_q[i-1];
            err_d[i] = err_q[i-1];
         end
      end
   end

   assign bus.out_valid = v_q[PS-1];
   assign bus.output_o  = res_q[PS-1];
   assign bus.err_o     = err_q[PS-1];

   // Clear wins over a same-cycle increment.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (bus.out_valid && bus.out_ready && (|bus.err_o)
                   && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   assign err_cnt_o = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q   <= '0;
         rdy_q <= 1'b0;
         cnt_q <= '0;
         for (int k = 0; k < NL; k++) begin
            for (int c = 0; c < NC; c++) begin
               tbl_q[k][c] <= '0;
            end
         end
         for (int i = 0; i < PS; i++) begin
            res_q[i] <= '0;
            err_q[i] <= '0;
         end
      end else begin
         v_q   <= v_d;
         rdy_q <= rdy_d;
         cnt_q <= cnt_d;
         tbl_q <= tbl_d;
         res_q <= res_d;
         err_q <= err_d;
      end
   end
endmodule
